// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception sequencer: cause codes, flag positions,
// CP0 field positions, stall patterns and FSM encoding.
package except_defs;

    localparam logic [31:0] CODE_NONE     = 32'h00000000;
    localparam logic [31:0] CODE_INT      = 32'h00000001;
    localparam logic [31:0] CODE_SYSCALL  = 32'h00000008;
    localparam logic [31:0] CODE_INVALID  = 32'h0000000a;
    localparam logic [31:0] CODE_OVERFLOW = 32'h0000000c;
    localparam logic [31:0] CODE_TRAP     = 32'h0000000d;
    localparam logic [31:0] CODE_ERET     = 32'h0000000e;

    localparam int FLAG_SYSCALL  = 8;
    localparam int FLAG_INVALID  = 9;
    localparam int FLAG_TRAP     = 10;
    localparam int FLAG_OVERFLOW = 11;
    localparam int FLAG_ERET     = 12;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_HI      = 15;
    localparam int IM_LO      = 8;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/except_prio.sv
// Interrupt qualification and fixed-priority selection of the MEM-stage event.
module except_prio
    import except_defs::*;
(
    input  logic [31:0] excepttype,
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic        mem_valid,
    output logic        event_valid,
    output logic        is_eret,
    output logic [31:0] code
);

    logic int_pending;
    logic unused_bits;

    assign unused_bits = ^{excepttype[31:13], excepttype[7:0],
                           status[31:16], status[7:2], cause[31:16], cause[7:0]};

    assign int_pending = mem_valid && status[STATUS_IE] && !status[STATUS_EXL] &&
                         ((cause[IM_HI:IM_LO] & status[IM_HI:IM_LO]) != 8'h00);

    // A bubble in MEM carries no event; interrupts win over every flag.
    always_comb begin
        code    = CODE_NONE;
        is_eret = 1'b0;
        if (int_pending) begin
            code = CODE_INT;
        end else if (mem_valid) begin
            if (excepttype[FLAG_SYSCALL]) begin
                code = CODE_SYSCALL;
            end else if (excepttype[FLAG_INVALID]) begin
                code = CODE_INVALID;
            end else if (excepttype[FLAG_TRAP]) begin
                code = CODE_TRAP;
            end else if (excepttype[FLAG_OVERFLOW]) begin
                code = CODE_OVERFLOW;
            end else if (excepttype[FLAG_ERET]) begin
                code    = CODE_ERET;
                is_eret = 1'b1;
            end
        end
    end

    assign event_valid = (code != CODE_NONE);

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: registers the selected event for CP0, drives
// flush/redirect for one cycle, then drains before accepting new events.
module except_ctrl
    import except_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic        mem_valid_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_inst_addr_o,
    output logic        cp0_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o,
    output logic        busy_o
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] drain_cnt, drain_cnt_nxt;
    logic          event_valid;
    logic          is_eret;
    logic [31:0]   code;
    logic [31:0]   excepttype_nxt;
    logic [31:0]   inst_addr_nxt;
    logic          delayslot_nxt;
    logic          flush_nxt;
    logic [31:0]   new_pc_nxt;
    logic [5:0]    stall_nxt;

    except_prio u_prio (
        .excepttype  (excepttype_i),
        .status      (cp0_status_i),
        .cause       (cp0_cause_i),
        .mem_valid   (mem_valid_i),
        .event_valid (event_valid),
        .is_eret     (is_eret),
        .code        (code)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            drain_cnt       <= '0;
            excepttype_o    <= '0;
            cp0_inst_addr_o <= '0;
            cp0_delayslot_o <= 1'b0;
            flush_o         <= 1'b0;
            new_pc_o        <= '0;
            stall_o         <= '0;
        end else begin
            state           <= state_nxt;
            drain_cnt       <= drain_cnt_nxt;
            excepttype_o    <= excepttype_nxt;
            cp0_inst_addr_o <= inst_addr_nxt;
            cp0_delayslot_o <= delayslot_nxt;
            flush_o         <= flush_nxt;
            new_pc_o        <= new_pc_nxt;
            stall_o         <= stall_nxt;
        end
    end

    // Outputs default to zero so the CP0 code is only ever live for the FLUSH cycle.
    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        excepttype_nxt = CODE_NONE;
        inst_addr_nxt  = '0;
        delayslot_nxt  = 1'b0;
        flush_nxt      = 1'b0;
        new_pc_nxt     = '0;
        stall_nxt      = STALL_NONE;
        case (state)
            ST_IDLE: begin
                if (event_valid) begin
                    excepttype_nxt = code;
                    inst_addr_nxt  = current_inst_addr_i;
                    delayslot_nxt  = is_in_delayslot_i;
                    flush_nxt      = 1'b1;
                    new_pc_nxt     = is_eret ? cp0_epc_i : EXC_VECTOR;
                    state_nxt      = ST_FLUSH;
                end else if (stallreq_ex_i) begin
                    stall_nxt = STALL_EX;
                end else if (stallreq_id_i) begin
                    stall_nxt = STALL_ID;
                end
            end
            ST_FLUSH: begin
                drain_cnt_nxt = '0;
                state_nxt     = (FLUSH_CYCLES > 0) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (32'(drain_cnt) == FLUSH_CYCLES - 1) begin
                    drain_cnt_nxt = '0;
                    state_nxt     = ST_IDLE;
                end else begin
                    drain_cnt_nxt = drain_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    assign busy_o = (state != ST_IDLE);

endmodule
